// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control FSM: sequences the shared ALU, unified memory
// and PC/IR/OldPC/ALUOut/Data registers; flags unsupported opcodes.
module riscv_mc_controller #(
  parameter bit BNE_EN          = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  state_e state_q, state_d;

  logic op_lw, op_sw, op_r, op_i, op_jal, op_br, op_ok;
  logic pc_update, branch, adr_src, mem_write;
  logic ir_write, reg_write, illegal_s;
  logic [1:0] result_src, src_a, src_b, alu_op;
  logic br_taken;

  assign op_lw  = (op == 7'b0000011);
  assign op_sw  = (op == 7'b0100011);
  assign op_r   = (op == 7'b0110011);
  assign op_i   = (op == 7'b0010011);
  assign op_jal = (op == 7'b1101111);
  assign op_br  = (op == 7'b1100011);
  assign op_ok  = op_lw | op_sw | op_r | op_i | op_jal | op_br;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          op_lw, op_sw: state_d = S_MEMADR;
          op_r:         state_d = S_EXECR;
          op_i:         state_d = S_EXECI;
          op_jal:       state_d = S_JAL;
          op_br:        state_d = S_BRANCH;
          default:      state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = op_sw ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal_s  = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        src_b      = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        src_a     = 2'b01;
        src_b     = 2'b01;
        illegal_s = !HALT_ON_ILLEGAL && !op_ok;
      end
      S_MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        src_a  = 2'b10;
        alu_op = 2'b10;
      end
      S_EXECI: begin
        src_a  = 2'b10;
        src_b  = 2'b01;
        alu_op = 2'b10;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        src_a     = 2'b01;
        src_b     = 2'b10;
        pc_update = 1'b1;
      end
      S_BRANCH: begin
        src_a  = 2'b10;
        alu_op = 2'b01;
        branch = 1'b1;
      end
      S_HALT:  illegal_s = 1'b1;
      default: ;
    endcase
  end

  assign br_taken = BNE_EN ? (Zero ^ funct3[0]) : Zero;

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    unique case (1'b1)
      op_sw:   ImmSrc = 2'b01;
      op_br:   ImmSrc = 2'b10;
      op_jal:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // write enables forced low while reset is held, even mid-instruction
  assign PCWrite   = ~reset & (pc_update | (branch & br_taken));
  assign MemWrite  = ~reset & mem_write;
  assign IRWrite   = ~reset & ir_write;
  assign RegWrite  = ~reset & reg_write;
  assign illegal   = ~reset & illegal_s;
  assign AdrSrc    = adr_src;
  assign ResultSrc = result_src;
  assign ALUSrcA   = src_a;
  assign ALUSrcB   = src_b;
  assign state_o   = state_q;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed vector bench for riscv_mc_controller, default build plus a
// NOP-on-illegal build driven by the same stimulus.
module tb_riscv_mc_controller;

  localparam logic [3:0] FE = 4'd0,  DE = 4'd1,  MA = 4'd2,  MR = 4'd3;
  localparam logic [3:0] MB = 4'd4,  MW = 4'd5,  ER = 4'd6,  EI = 4'd7;
  localparam logic [3:0] AW = 4'd8,  JL = 4'd9,  BR = 4'd10, HT = 4'd11;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] aluc;
    logic       ill;
  } out_t;

  typedef struct {
    string      nm;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0;
  logic Zero = 1'b0;

  logic pcw1, adr1, mw1, irw1, rw1, ill1;
  logic [1:0] res1, sa1, sb1, imm1;
  logic [2:0] aluc1;
  logic [3:0] st1;
  logic pcw2, adr2, mw2, irw2, rw2, ill2;
  logic [1:0] res2, sa2, sb2, imm2;
  logic [2:0] aluc2;
  logic [3:0] st2;

  out_t o1, o2;
  assign o1 = {st1, pcw1, adr1, mw1, irw1, rw1,
               res1, sa1, sb1, imm1, aluc1, ill1};
  assign o2 = {st2, pcw2, adr2, mw2, irw2, rw2,
               res2, sa2, sb2, imm2, aluc2, ill2};

  always #5 clk = ~clk;

  riscv_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1),
    .RegWrite(rw1), .ResultSrc(res1), .ALUSrcA(sa1), .ALUSrcB(sb1),
    .ImmSrc(imm1), .ALUControl(aluc1), .illegal(ill1), .state_o(st1)
  );

  riscv_mc_controller #(.BNE_EN(1'b1), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2),
    .RegWrite(rw2), .ResultSrc(res2), .ALUSrcA(sa2), .ALUSrcB(sb2),
    .ImmSrc(imm2), .ALUControl(aluc2), .illegal(ill2), .state_o(st2)
  );

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];

  function automatic out_t mk(logic [3:0] st, logic [4:0] en,
                              logic [1:0] res, logic [1:0] sa,
                              logic [1:0] sb, logic [1:0] imm,
                              logic [2:0] aluc, logic ill);
    return {st, en, res, sa, sb, imm, aluc, ill};
  endfunction

  function automatic void add(string nm, logic [6:0] o, logic [2:0] f3,
                              logic f7, logic z, out_t e);
    vec_t v;
    v.nm = nm; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, out_t e1, out_t e2, bit both);
    n_vec++;
    if (o1 !== e1 || (both && o2 !== e2)) begin
      n_err++;
      $display("FAIL %s: got %h / %h, want %h / %h", nm, o1, o2, e1, e2);
    end
  endtask

  task automatic drive(logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_t rst_e, e;
    rst_e = mk(FE, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);

    // addi
    add("addi F",  7'b0010011, 3'b000, 0, 0, mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    add("addi D",  7'b0010011, 3'b000, 0, 0, mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    add("addi EI", 7'b0010011, 3'b000, 0, 0, mk(EI,5'b00000,2'b00,2'b10,2'b01,2'b00,3'b000,0));
    add("addi WB", 7'b0010011, 3'b000, 0, 0, mk(AW,5'b00001,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    // lw
    add("lw F",  7'b0000011, 3'b010, 0, 0, mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    add("lw D",  7'b0000011, 3'b010, 0, 0, mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    add("lw MA", 7'b0000011, 3'b010, 0, 0, mk(MA,5'b00000,2'b00,2'b10,2'b01,2'b00,3'b000,0));
    add("lw MR", 7'b0000011, 3'b010, 0, 0, mk(MR,5'b01000,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    add("lw MB", 7'b0000011, 3'b010, 0, 0, mk(MB,5'b00001,2'b01,2'b00,2'b00,2'b00,3'b000,0));
    // sw
    add("sw F",  7'b0100011, 3'b010, 0, 0, mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b01,3'b000,0));
    add("sw D",  7'b0100011, 3'b010, 0, 0, mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b01,3'b000,0));
    add("sw MA", 7'b0100011, 3'b010, 0, 0, mk(MA,5'b00000,2'b00,2'b10,2'b01,2'b01,3'b000,0));
    add("sw MW", 7'b0100011, 3'b010, 0, 0, mk(MW,5'b01100,2'b00,2'b00,2'b00,2'b01,3'b000,0));
    // sub
    add("sub F",  7'b0110011, 3'b000, 1, 0, mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    add("sub D",  7'b0110011, 3'b000, 1, 0, mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    add("sub ER", 7'b0110011, 3'b000, 1, 0, mk(ER,5'b00000,2'b00,2'b10,2'b00,2'b00,3'b001,0));
    add("sub WB", 7'b0110011, 3'b000, 1, 0, mk(AW,5'b00001,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    // beq taken; Zero=1 must not leak into DECODE
    add("beq1 F",  7'b1100011, 3'b000, 0, 1, mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b10,3'b000,0));
    add("beq1 D",  7'b1100011, 3'b000, 0, 1, mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b10,3'b000,0));
    add("beq1 BR", 7'b1100011, 3'b000, 0, 1, mk(BR,5'b10000,2'b00,2'b10,2'b00,2'b10,3'b001,0));
    // bne Zero=1 not taken
    add("bne1 F",  7'b1100011, 3'b001, 0, 1, mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b10,3'b000,0));
    add("bne1 D",  7'b1100011, 3'b001, 0, 1, mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b10,3'b000,0));
    add("bne1 BR", 7'b1100011, 3'b001, 0, 1, mk(BR,5'b00000,2'b00,2'b10,2'b00,2'b10,3'b001,0));
    // bne Zero=0 taken
    add("bne0 F",  7'b1100011, 3'b001, 0, 0, mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b10,3'b000,0));
    add("bne0 D",  7'b1100011, 3'b001, 0, 0, mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b10,3'b000,0));
    add("bne0 BR", 7'b1100011, 3'b001, 0, 0, mk(BR,5'b10000,2'b00,2'b10,2'b00,2'b10,3'b001,0));
    // beq Zero=0 not taken
    add("beq0 F",  7'b1100011, 3'b000, 0, 0, mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b10,3'b000,0));
    add("beq0 D",  7'b1100011, 3'b000, 0, 0, mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b10,3'b000,0));
    add("beq0 BR", 7'b1100011, 3'b000, 0, 0, mk(BR,5'b00000,2'b00,2'b10,2'b00,2'b10,3'b001,0));
    // addi with IR[30]=1 stays add
    add("addi7 F",  7'b0010011, 3'b000, 1, 0, mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    add("addi7 D",  7'b0010011, 3'b000, 1, 0, mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    add("addi7 EI", 7'b0010011, 3'b000, 1, 0, mk(EI,5'b00000,2'b00,2'b10,2'b01,2'b00,3'b000,0));
    add("addi7 WB", 7'b0010011, 3'b000, 1, 0, mk(AW,5'b00001,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    // jal
    add("jal F",  7'b1101111, 3'b000, 0, 0, mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b11,3'b000,0));
    add("jal D",  7'b1101111, 3'b000, 0, 0, mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b11,3'b000,0));
    add("jal J",  7'b1101111, 3'b000, 0, 0, mk(JL,5'b10000,2'b00,2'b01,2'b10,2'b11,3'b000,0));
    add("jal WB", 7'b1101111, 3'b000, 0, 0, mk(AW,5'b00001,2'b00,2'b00,2'b00,2'b11,3'b000,0));
    // and
    add("and F",  7'b0110011, 3'b111, 0, 0, mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    add("and D",  7'b0110011, 3'b111, 0, 0, mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    add("and ER", 7'b0110011, 3'b111, 0, 0, mk(ER,5'b00000,2'b00,2'b10,2'b00,2'b00,3'b010,0));
    add("and WB", 7'b0110011, 3'b111, 0, 0, mk(AW,5'b00001,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    // slti
    add("slti F",  7'b0010011, 3'b010, 0, 0, mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    add("slti D",  7'b0010011, 3'b010, 0, 0, mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    add("slti EI", 7'b0010011, 3'b010, 0, 0, mk(EI,5'b00000,2'b00,2'b10,2'b01,2'b00,3'b101,0));
    add("slti WB", 7'b0010011, 3'b010, 0, 0, mk(AW,5'b00001,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    // or
    add("or F",  7'b0110011, 3'b110, 0, 0, mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    add("or D",  7'b0110011, 3'b110, 0, 0, mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    add("or ER", 7'b0110011, 3'b110, 0, 0, mk(ER,5'b00000,2'b00,2'b10,2'b00,2'b00,3'b011,0));
    add("or WB", 7'b0110011, 3'b110, 0, 0, mk(AW,5'b00001,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    // xor funct3 with IR[30]=1 falls back to add
    add("xor F",  7'b0110011, 3'b100, 1, 0, mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    add("xor D",  7'b0110011, 3'b100, 1, 0, mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    add("xor ER", 7'b0110011, 3'b100, 1, 0, mk(ER,5'b00000,2'b00,2'b10,2'b00,2'b00,3'b000,0));
    add("xor WB", 7'b0110011, 3'b100, 1, 0, mk(AW,5'b00001,2'b00,2'b00,2'b00,2'b00,3'b000,0));

    // reset held 3 cycles
    #1;
    chk("rst0", rst_e, rst_e, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst%0d", i + 1), rst_e, rst_e, 1);
    end
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
      #1;
      chk(vecs[i].nm, vecs[i].exp, vecs[i].exp, 1);
      step();
    end

    // illegal opcode: default build halts, NOP build pulses once
    drive(7'b1111111, 3'b000, 0, 0);
    #1;
    e = mk(FE,5'b10010,2'b10,2'b00,2'b10,2'b00,3'b000,0);
    chk("ill F", e, e, 1);
    step();
    chk("ill D",
        mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b00,3'b000,0),
        mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b00,3'b000,1), 1);
    step();
    chk("ill H0",
        mk(HT,5'b00000,2'b00,2'b00,2'b00,2'b00,3'b000,1), e, 1);
    drive(7'b0010011, 3'b000, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("halt%0d", i),
          mk(HT,5'b00000,2'b00,2'b00,2'b00,2'b00,3'b000,1), e, 0);
    end

    // async reset out of HALT
    reset = 1'b1;
    #1;
    chk("hrst0", rst_e, rst_e, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hrst%0d", i + 1), rst_e, rst_e, 1);
    end
    reset = 1'b0;
    #1;
    chk("hrst rel", e, e, 1);

    // lw aborted in MEMREAD by a mid-cycle reset
    drive(7'b0000011, 3'b010, 0, 0);
    step();
    step();
    step();
    chk("abort MR",
        mk(MR,5'b01000,2'b00,2'b00,2'b00,2'b00,3'b000,0),
        mk(MR,5'b01000,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort rst", rst_e, rst_e, 1);
    step();
    chk("abort hold", rst_e, rst_e, 1);
    reset = 1'b0;
    #1;
    chk("abort rel", e, e, 1);
    step();
    chk("abort D",
        mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b00,3'b000,0),
        mk(DE,5'b00000,2'b00,2'b01,2'b01,2'b00,3'b000,0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
